// File: rtl/gpu_pixel_write_buffer.sv
// gpu_pixel_write_buffer
//
// Collects blended pixels from the write-back stage into 16-pixel line blocks.
// Each block is aligned to a VRAM line segment and carries a per-pixel write
// mask. Finished blocks go to the VRAM write arbiter as single burst requests.
//
// Two banks are used. FILL gathers incoming pixels. PEND holds the block that
// is currently offered to the arbiter. The pipeline is stalled only when a
// pixel needs a new block while PEND is still waiting for its acknowledge, or
// while a requested flush has not yet been able to move FILL into PEND.
//
// Ports:
//   clk                clock
//   i_rst              synchronous active-high reset
//   i_pixelValid       a pixel is presented this cycle
//   i_scrX[9:0]        pixel X coordinate
//   i_scrY[8:0]        pixel Y coordinate
//   i_color[15:0]      final pixel value (bit15 is the VRAM mask bit)
//   i_blockTransition  non-zero: flush FILL after this cycle's pixel
//   i_flushAll         level: flush every cycle it is high
//   o_pause            stall upstream; inputs are not consumed this cycle
//   o_idle             nothing buffered, nothing requested, no flush waiting
//   o_writeReq         block write request (held until i_writeAck)
//   o_writeAdr[14:0]   {scrY, scrX[9:4]} of the block
//   o_writeData[255:0] pixel n at bits [16n+15:16n]
//   o_writeMask[15:0]  bit n set when pixel n was written
//   i_writeAck         arbiter accepted the request this cycle
//   o_statBlocks[15:0] accepted request count (statistics build only)
//   o_statStall[15:0]  stall cycle count (statistics build only)
//
// Build option:
//   GPU_WBUF_STATS_EN  when defined, o_statBlocks/o_statStall are saturating
//                      counters; otherwise both are tied to zero.

module gpu_pixel_write_buffer #(
    parameter int BLOCK_LOG2 = 4
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_pixelValid,
    input  logic [9:0]   i_scrX,
    input  logic [8:0]   i_scrY,
    input  logic [15:0]  i_color,
    input  logic [1:0]   i_blockTransition,
    input  logic         i_flushAll,
    output logic         o_pause,
    output logic         o_idle,
    output logic         o_writeReq,
    output logic [14:0]  o_writeAdr,
    output logic [255:0] o_writeData,
    output logic [15:0]  o_writeMask,
    input  logic         i_writeAck,
    output logic [15:0]  o_statBlocks,
    output logic [15:0]  o_statStall
);

    localparam int SLOTS  = 1 << BLOCK_LOG2;
    localparam int TAG_W  = 9 + 10 - BLOCK_LOG2;
    localparam int DATA_W = SLOTS * 16;

    // FILL bank
    logic              fValid;
    logic [TAG_W-1:0]  fillTag;
    logic [DATA_W-1:0] fillData;
    logic [SLOTS-1:0]  fillMask;

    // PEND bank
    logic              pValid;
    logic [TAG_W-1:0]  pendTag;
    logic [DATA_W-1:0] pendData;
    logic [SLOTS-1:0]  pendMask;

    logic              flushPending;

    // Decoded per-cycle control
    logic [TAG_W-1:0]      tagIn;
    logic [BLOCK_LOG2-1:0] slot;
    logic [SLOTS-1:0]      slotHot;
    logic                  tagMismatch;
    logic                  pendFree;
    logic                  pause;
    logic                  pixelAccept;
    logic                  transAccept;
    logic                  startFresh;
    logic                  handoffOnPixel;
    logic                  handoffOnFlush;
    logic                  loadPend;

    // Decode the incoming pixel against the FILL bank and work out what this
    // cycle does. PEND counts as free when it is empty or when the arbiter
    // takes it this very cycle, so a block can be handed over in the same
    // cycle the previous one is acknowledged. While a flush is waiting the
    // pipeline is held, which also guarantees that a pixel is never accepted
    // in the same cycle as a flush-driven handoff.
    always_comb begin
        tagIn          = {i_scrY, i_scrX[9:BLOCK_LOG2]};
        slot           = i_scrX[BLOCK_LOG2-1:0];
        slotHot        = '0;
        slotHot[slot]  = 1'b1;

        tagMismatch    = fValid && (tagIn != fillTag);
        pendFree       = !pValid || i_writeAck;

        pause          = flushPending || (i_pixelValid && tagMismatch && !pendFree);

        pixelAccept    = i_pixelValid && !pause;
        transAccept    = ((i_blockTransition != 2'b00) || i_flushAll) && !pause;
        startFresh     = !fValid || tagMismatch;

        handoffOnPixel = pixelAccept && tagMismatch;
        handoffOnFlush = flushPending && pendFree && fValid;
        loadPend       = handoffOnPixel || handoffOnFlush;
    end

    // Control state: valid flags, masks and the pending flush. A handoff
    // always wins over an acknowledge because the acknowledge is exactly what
    // made room for it. A transition accepted in the same cycle as a pixel
    // only takes effect from the next cycle, so the pixel lands in FILL first
    // and then travels with the flushed block.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            fValid       <= 1'b0;
            pValid       <= 1'b0;
            flushPending <= 1'b0;
            fillMask     <= '0;
            pendMask     <= '0;
        end else begin
            if (loadPend) begin
                pValid   <= 1'b1;
                pendMask <= fillMask;
            end else if (i_writeAck) begin
                pValid   <= 1'b0;
            end

            if (pixelAccept) begin
                fValid <= 1'b1;
                if (startFresh) begin
                    fillMask <= slotHot;
                end else begin
                    fillMask <= fillMask | slotHot;
                end
            end else if (handoffOnFlush) begin
                fValid <= 1'b0;
            end

            if (transAccept) begin
                flushPending <= 1'b1;
            end else if (flushPending && pendFree) begin
                flushPending <= 1'b0;
            end
        end
    end

    // Block tags and pixel storage. These carry no reset because they are
    // only ever looked at through the valid flags and masks. Slots not
    // covered by the mask may hold pixels from an older block; the mask tells
    // the arbiter to skip them. Rewriting a slot simply overwrites it, so the
    // last write to a pixel wins.
    always_ff @(posedge clk) begin
        if (loadPend) begin
            pendTag  <= fillTag;
            pendData <= fillData;
        end
        if (pixelAccept) begin
            if (startFresh) begin
                fillTag <= tagIn;
            end
            fillData[int'(slot) * 16 +: 16] <= i_color;
        end
    end

    assign o_pause     = pause;
    assign o_idle      = !fValid && !pValid && !flushPending;
    assign o_writeReq  = pValid;
    assign o_writeAdr  = pendTag;
    assign o_writeData = pendData;
    assign o_writeMask = pendMask;

`ifdef GPU_WBUF_STATS_EN
    logic [15:0] statBlocks;
    logic [15:0] statStall;

    // Saturating statistics: accepted block requests and stalled cycles.
    // Saturation keeps long runs from wrapping back to small, misleading
    // numbers.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            statBlocks <= '0;
            statStall  <= '0;
        end else begin
            if (pValid && i_writeAck && (statBlocks != 16'hFFFF)) begin
                statBlocks <= statBlocks + 16'd1;
            end
            if (pause && (statStall != 16'hFFFF)) begin
                statStall <= statStall + 16'd1;
            end
        end
    end

    assign o_statBlocks = statBlocks;
    assign o_statStall  = statStall;
`else
    assign o_statBlocks = '0;
    assign o_statStall  = '0;
`endif

endmodule
